// File: rtl/alu_link_pkg.sv
// Shared definitions for the serial operand link between the loader and the ALU.
package alu_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } link_state_t;

    localparam int DRV_DATA   = 0;
    localparam int DRV_SEL    = 1;
    localparam int DRV_SAVE   = 2;
    localparam int DRV_OP_LSB = 3;
    localparam int DRV_OP_MSB = 5;

    // Assemble one ui_drive word; bits [7:6] are always left at zero.
    function automatic logic [7:0] link_word(input logic data, input logic sel,
                                             input logic save, input logic [2:0] op);
        logic [7:0] w;
        w                        = '0;
        w[DRV_DATA]              = data;
        w[DRV_SEL]               = sel;
        w[DRV_SAVE]              = save;
        w[DRV_OP_MSB:DRV_OP_LSB] = op;
        return w;
    endfunction

endpackage

// File: rtl/alu_serial_loader.sv
// Loads an operand pair into the ALU one bit at a time (A then B, MSB first),
// waits SETTLE_CYCLES for the ALU to settle, then captures its result.
//
// state  | meaning
// IDLE   | waiting for start; link driven to zero
// SETUP  | data/sel presented, save strobe low
// STROBE | same data/sel with save strobe high for one cycle
// SETTLE | all bits sent; waiting for the ALU result to settle
// DONE   | result_q newly valid, done pulse
module alu_serial_loader
    import alu_link_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    input  logic [2:0] op_in,
    output logic [7:0] ui_drive,
    input  logic [7:0] result_in,
    output logic [7:0] result_q,
    output logic       busy,
    output logic       done
);

    // The settle counter counts down to zero, so it is loaded one short.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    link_state_t r_state;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [2:0]  r_op;
    logic        r_sel;
    logic [2:0]  r_idx;
    logic [3:0]  r_cnt;
    logic [7:0]  r_drive;
    logic [7:0]  r_result;
    logic        r_busy;
    logic        r_done;

    logic [7:0]  w_operand;
    logic [2:0]  w_idx_nxt;

    assign w_operand = r_sel ? r_b : r_a;
    assign w_idx_nxt = r_idx - 3'd1;

    // Sequencer: every output is computed one edge ahead and held in a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_sel    <= 1'b0;
            r_idx    <= 3'd7;
            r_cnt    <= '0;
            r_drive  <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_op    <= op_in;
                        r_sel   <= 1'b0;
                        r_idx   <= 3'd7;
                        r_busy  <= 1'b1;
                        r_drive <= link_word(a_in[7], 1'b0, 1'b0, op_in);
                        r_state <= ST_SETUP;
                    end else begin
                        r_busy  <= 1'b0;
                        r_drive <= '0;
                    end
                end
                ST_SETUP: begin
                    r_drive[DRV_SAVE] <= 1'b1;
                    r_state           <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (r_idx != 3'd0) begin
                        r_idx   <= w_idx_nxt;
                        r_drive <= link_word(w_operand[w_idx_nxt], r_sel, 1'b0, r_op);
                        r_state <= ST_SETUP;
                    end else if (!r_sel) begin
                        r_sel   <= 1'b1;
                        r_idx   <= 3'd7;
                        r_drive <= link_word(r_b[7], 1'b1, 1'b0, r_op);
                        r_state <= ST_SETUP;
                    end else begin
                        // Op stays on the link so the ALU keeps computing the same function.
                        r_cnt   <= SETTLE_LOAD;
                        r_drive <= link_word(1'b0, 1'b0, 1'b0, r_op);
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        r_result <= result_in;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_drive <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_drive <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ui_drive = r_drive;
    assign result_q = r_result;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_alu_serial_loader.sv
// Directed bench for alu_serial_loader with a small serial-input ALU model.
module tb_alu_serial_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [2:0] op_in;
    logic [7:0] ui_drive;
    logic [7:0] result_in;
    logic [7:0] result_q;
    logic       busy;
    logic       done;

    logic [7:0] s1_drive, s1_result_q, s15_drive, s15_result_q;
    logic       s1_busy, s1_done, s15_busy, s15_done;
    logic [7:0] tick;

    int vectors     = 0;
    int miscompares = 0;
    int edge_cnt    = 0;

    int         s1_done_edge, s15_done_edge;
    logic [7:0] s1_res, s15_res;

    logic [7:0] alu_a, alu_b;

    always #5 clk = ~clk;

    alu_serial_loader #(.SETTLE_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in), .op_in(op_in),
        .ui_drive(ui_drive), .result_in(result_in), .result_q(result_q), .busy(busy), .done(done));

    alu_serial_loader #(.SETTLE_CYCLES(1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in), .op_in(op_in),
        .ui_drive(s1_drive), .result_in(tick), .result_q(s1_result_q), .busy(s1_busy), .done(s1_done));

    alu_serial_loader #(.SETTLE_CYCLES(15)) u_dut_s15 (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in), .op_in(op_in),
        .ui_drive(s15_drive), .result_in(tick), .result_q(s15_result_q), .busy(s15_busy), .done(s15_done));

    always @(posedge clk) edge_cnt++;

    // Marker value on the result bus of the settle-length instances: changes mid-cycle.
    always @(negedge clk) tick = edge_cnt[7:0];

    always @(negedge clk) begin
        if (s1_done) begin
            s1_done_edge = edge_cnt;
            s1_res       = s1_result_q;
        end
        if (s15_done) begin
            s15_done_edge = edge_cnt;
            s15_res       = s15_result_q;
        end
    end

    // ALU model: operand shift registers clocked by the save strobe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a <= '0;
            alu_b <= '0;
        end else if (ui_drive[2]) begin
            if (ui_drive[1]) alu_b <= {alu_b[6:0], ui_drive[0]};
            else             alu_a <= {alu_a[6:0], ui_drive[0]};
        end
    end

    always_comb begin
        case (ui_drive[5:3])
            3'd0:    result_in = alu_a + alu_b;
            3'd1:    result_in = alu_a - alu_b;
            3'd2:    result_in = alu_a & alu_b;
            3'd3:    result_in = alu_a | alu_b;
            default: result_in = alu_a ^ alu_b;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start one transaction and watch it cycle by cycle (cycle 1 = first after acceptance).
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                           input bit hold, input int chg_cyc, input logic [7:0] chg_a,
                           output logic [15:0] bits, output logic [15:0] sels,
                           output int nstb, output int last_stb, output int done_cyc,
                           output logic [7:0] setup_drive, output logic [7:0] done_drive,
                           output logic done_busy, output logic [7:0] done_res, output int e0);
        bits = '0; sels = '0; nstb = 0; last_stb = -1; done_cyc = -1;
        setup_drive = '0; done_drive = '0; done_busy = 1'b1; done_res = '0;
        a_in = a; b_in = b; op_in = op; start = 1'b1;
        @(posedge clk); #1;
        e0 = edge_cnt;
        if (!hold) start = 1'b0;
        for (int n = 1; n <= 80; n++) begin
            if (n == chg_cyc) begin
                a_in  = chg_a;
                b_in  = ~b;
                op_in = ~op;
            end
            if (n == 1) setup_drive = ui_drive;
            if (ui_drive[2]) begin
                bits = {bits[14:0], ui_drive[0]};
                sels = {sels[14:0], ui_drive[1]};
                nstb++;
                last_stb = n;
            end
            if (done) begin
                done_cyc   = n;
                done_drive = ui_drive;
                done_busy  = busy;
                done_res   = result_q;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    logic [15:0] bits, sels;
    int          nstb, last_stb, done_cyc, e0;
    logic [7:0]  setup_drive, done_drive, done_res;
    logic        done_busy;
    bit          seen;

    initial begin
        rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; op_in = '0;
        s1_done_edge = -1; s15_done_edge = -1; s1_res = '0; s15_res = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ui_drive", ui_drive, 8'h00);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset result_q", result_q, 8'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // A=A5, B=3C, ADD: bit order, sel, strobe count and timing
        run_txn(8'hA5, 8'h3C, 3'd0, 1'b0, 0, 8'h00, bits, sels, nstb, last_stb, done_cyc,
                setup_drive, done_drive, done_busy, done_res, e0);
        chk("a5 strobe bits", bits, 16'hA53C);
        chk("a5 strobe sels", sels, 16'h00FF);
        chk("a5 strobe count", nstb, 16);
        chk("a5 last strobe cycle", last_stb, 32);
        chk("a5 first setup drive", setup_drive, 8'h01);
        chk("a5 done cycle", done_cyc, 35);
        chk("a5 busy at done", done_busy, 1'b0);
        chk("a5 drive at done", done_drive, 8'h00);
        chk("a5 result", done_res, 8'hE1);
        repeat (16) @(posedge clk);
        #1;
        chk("s1 done edge", s1_done_edge, e0 + 33);
        chk("s15 done edge", s15_done_edge, e0 + 47);
        chk("s1 captured", s1_res, 8'(e0 + 32));
        chk("s15 captured", s15_res, 8'(e0 + 46));
        chk("result held", result_q, 8'hE1);

        // A=0F, B=F0, ADD through the ALU model
        run_txn(8'h0F, 8'hF0, 3'd0, 1'b0, 0, 8'h00, bits, sels, nstb, last_stb, done_cyc,
                setup_drive, done_drive, done_busy, done_res, e0);
        chk("add alu_a", alu_a, 8'h0F);
        chk("add alu_b", alu_b, 8'hF0);
        chk("add result", done_res, 8'hFF);
        chk("add done cycle", done_cyc, 35);
        @(posedge clk); #1;

        // AND op: op field on the link
        run_txn(8'hC3, 8'h5A, 3'd2, 1'b0, 0, 8'h00, bits, sels, nstb, last_stb, done_cyc,
                setup_drive, done_drive, done_busy, done_res, e0);
        chk("and setup drive", setup_drive, 8'h11);
        chk("and done drive", done_drive, 8'h10);
        chk("and result", done_res, 8'h42);
        @(posedge clk); #1;

        // Inputs change in cycle 5 after acceptance
        run_txn(8'hFF, 8'h81, 3'd1, 1'b0, 5, 8'h00, bits, sels, nstb, last_stb, done_cyc,
                setup_drive, done_drive, done_busy, done_res, e0);
        chk("late change bits", bits, 16'hFF81);
        chk("late change result", done_res, 8'h7E);
        chk("late change done cycle", done_cyc, 35);
        @(posedge clk); #1;

        // start held high
        run_txn(8'h12, 8'h34, 3'd0, 1'b1, 0, 8'h00, bits, sels, nstb, last_stb, done_cyc,
                setup_drive, done_drive, done_busy, done_res, e0);
        chk("held done cycle", done_cyc, 35);
        chk("held no strobe in done", done_drive[2], 1'b0);
        chk("held strobe count", nstb, 16);
        @(posedge clk); #1;
        chk("held idle busy", busy, 1'b0);
        chk("held idle drive", ui_drive, 8'h00);
        @(posedge clk); #1;
        chk("held restart busy", busy, 1'b1);
        chk("held restart drive", ui_drive, 8'h00);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        chk("held second done", seen, 1'b1);
        chk("held second result", result_q, 8'h46);
        @(posedge clk); #1;

        // Reset during the A phase
        a_in = 8'hAA; b_in = 8'h55; op_in = 3'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid busy before reset", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset drive", ui_drive, 8'h00);
        chk("async reset busy", busy, 1'b0);
        chk("async reset result", result_q, 8'h00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post release drive", ui_drive, 8'h00);
        chk("post release busy", busy, 1'b0);
        run_txn(8'h96, 8'h69, 3'd0, 1'b0, 0, 8'h00, bits, sels, nstb, last_stb, done_cyc,
                setup_drive, done_drive, done_busy, done_res, e0);
        chk("post reset bits", bits, 16'h9669);
        chk("post reset count", nstb, 16);
        chk("post reset setup drive", setup_drive, 8'h01);
        chk("post reset done cycle", done_cyc, 35);
        chk("post reset result", done_res, 8'hFF);
        repeat (20) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_serial_loader.md
ALU_SERIAL_LOADER -- requirements
Module: alu_serial_loader

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, range 1..15: number of cycles held after the last operand strobe before result capture.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to load one operand pair and run one op.
REQ-005 SHALL have port a_in  input  8  operand A, sampled at start acceptance.
REQ-006 SHALL have port b_in  input  8  operand B, sampled at start acceptance.
REQ-007 SHALL have port op_in  input  3  ALU op code, sampled at start acceptance.
REQ-008 SHALL have port ui_drive  output  8  serial link to ALU: [0] data bit, [1] sel_ab (0=A, 1=B), [2] save_bit strobe, [5:3] op, [7:6] always 0.
REQ-009 SHALL have port result_in  input  8  ALU result bus from ALU output.
REQ-010 SHALL have port result_q  output  8  captured ALU result.
REQ-011 SHALL have port busy  output  1  high while a transaction is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse: result_q newly valid.

Function
REQ-013 SHALL implement states IDLE, SETUP, STROBE, SETTLE, DONE.
REQ-014 IDLE: start=1 at a rising edge SHALL latch a_in/b_in/op_in, set sel=0 and bit index=7, and go to SETUP; start=0 stays in IDLE.
REQ-015 SETUP: ui_drive[0] = current operand bit at bit index, [1] = sel, [2] = 0; next state STROBE.
REQ-016 STROBE: same data/sel as preceding SETUP with [2] = 1 for exactly one cycle; bits SHALL be sent MSB first.
REQ-017 After STROBE: index>0 -> index-1, SETUP; index=0 and sel=0 -> sel=1, index=7, SETUP; index=0 and sel=1 -> SETTLE.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles with [2]=0; on its last edge result_in SHALL be captured into result_q; next state DONE.
REQ-019 DONE SHALL last one cycle with done=1, busy=0; next state IDLE.
REQ-020 Timing, start sampled at edge 0: first SETUP in cycle 1, final B strobe in cycle 32, done in cycle 33+SETTLE_CYCLES.
REQ-021 ui_drive[5:3] SHALL show latched op in all non-IDLE states and 0 in IDLE.
REQ-022 ui_drive[0] and ui_drive[1] SHALL be 0 in IDLE and DONE.
REQ-023 busy SHALL be 1 in SETUP, STROBE and SETTLE, and 0 otherwise.
REQ-024 start outside IDLE, including in DONE, SHALL be ignored; it is neither queued nor affects latched operands.
REQ-025 a_in, b_in and op_in changes after acceptance SHALL NOT affect the transaction.
REQ-026 result_q SHALL hold its value until the next capture.
REQ-027 All outputs SHALL be driven directly from registers, with no combinational path from any input.

Reset
REQ-028 rst_n=0 SHALL, asynchronously and at any state including mid-transfer, force IDLE: ui_drive=0, busy=0, done=0, result_q=0, latched operands=0, index=7, sel=0.
REQ-029 After reset release, the first accepted start SHALL behave per REQ-020; no partial strobe SHALL be emitted on release.

Structure
REQ-030 Shared package alu_link_pkg SHALL hold the state enum and the ui_drive bit-position constants (DATA=0, SEL=1, SAVE=2, OP_LSB=3, OP_MSB=5); the ALU top and this block both use it.
REQ-031 SHALL be a single module with no sub-module; the bit index and settle counter SHALL be internal registers.

Verification
REQ-032 A=0xA5, B=0x3C, op=0, SETTLE=2: A-phase strobes carry 1,0,1,0,0,1,0,1 with sel=0, then B-phase strobes carry 0,0,1,1,1,1,0,0 with sel=1; exactly 16 strobes total; done in cycle 35.
REQ-033 Loader connected to the ALU model, A=0x0F, B=0xF0, op=ADD: ALU A=0x0F and B=0xF0 after strobe 32; result_q=0xFF on the done pulse.
REQ-034 start held high continuously: only one transaction per IDLE entry; a new transaction begins the cycle after DONE returns to IDLE; no strobes during DONE.
REQ-035 rst_n low in cycle 10 (A phase), released in cycle 12: ui_drive=0 asynchronously; busy=0; next start sends a full 16 strobes from A bit 7.
REQ-036 SETTLE_CYCLES=1 and =15: done in cycle 34 and cycle 48 respectively; result_q captures the result_in value present on the last SETTLE edge.
REQ-037 a_in changed to 0x00 in cycle 5 after accepting 0xFF: all eight A strobes still carry 1.
